shootout_ctrl: RTL and testbench

- Match-level sequencer for the penalty-shootout game.
- Takes debounced mode-select pulses plus per-kick results from the keeper/shooter input decode (kick, save, invalid).
- Alternates teams A and B, keeps both scores and the round count, and ends the match early once the result is mathematically decided.
- If tied after regulation, runs capped sudden death, then drives match-status outputs to the display/LED logic.

---
 rtl/shootout_ctrl.sv | 151 +++++++++++++++
 tb/tb_shootout_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shootout_ctrl.sv
// Penalty-shootout match sequencer: alternating kicks, scores,
// early decision, capped sudden death and match-status outputs.
module shootout_ctrl #(
  parameter int SD_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode3,
  input  logic       mode5,
  input  logic       kick,
  input  logic       save,
  input  logic       invalid,
  output logic       turn,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [2:0] round,
  output logic [2:0] sd_round,
  output logic       playing,
  output logic       done,
  output logic [1:0] winner,
  output logic       goal_p,
  output logic       miss_p,
  output logic       reject_p
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SUDDEN,
    DONE
  } state_t;

  localparam logic [2:0] SD_LIM = 3'(SD_MAX);

  state_t     state;
  logic [2:0] n;
  logic [2:0] ka;
  logic [2:0] kb;

  logic       start;
  logic       hit;
  logic [3:0] sa_nx;
  logic [3:0] sb_nx;
  logic [2:0] ka_nx;
  logic [2:0] kb_nx;
  logic [3:0] rem_a;
  logic [3:0] rem_b;
  logic       a_wins;
  logic       b_wins;

  assign start = mode3 ^ mode5;
  assign hit   = ~save;

  // Post-kick values; the early decision looks at these, not the registers.
  always_comb begin
    sa_nx  = score_a + {3'b000, hit & ~turn};
    sb_nx  = score_b + {3'b000, hit & turn};
    ka_nx  = ka + {2'b00, ~turn};
    kb_nx  = kb + {2'b00, turn};
    rem_a  = {1'b0, n} - {1'b0, ka_nx};
    rem_b  = {1'b0, n} - {1'b0, kb_nx};
    a_wins = sa_nx > (sb_nx + rem_b);
    b_wins = sb_nx > (sa_nx + rem_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n        <= 3'd0;
      ka       <= 3'd0;
      kb       <= 3'd0;
      turn     <= 1'b0;
      score_a  <= 4'd0;
      score_b  <= 4'd0;
      round    <= 3'd0;
      sd_round <= 3'd0;
      playing  <= 1'b0;
      done     <= 1'b0;
      winner   <= 2'b00;
      goal_p   <= 1'b0;
      miss_p   <= 1'b0;
      reject_p <= 1'b0;
    end else begin
      goal_p   <= 1'b0;
      miss_p   <= 1'b0;
      reject_p <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= PLAY;
            n        <= mode5 ? 3'd5 : 3'd3;
            ka       <= 3'd0;
            kb       <= 3'd0;
            turn     <= 1'b0;
            score_a  <= 4'd0;
            score_b  <= 4'd0;
            round    <= 3'd1;
            sd_round <= 3'd0;
            playing  <= 1'b1;
            done     <= 1'b0;
            winner   <= 2'b00;
          end
        end
        PLAY, SUDDEN: begin
          if (kick && invalid) begin
            reject_p <= 1'b1;
          end else if (kick) begin
            score_a <= sa_nx;
            score_b <= sb_nx;
            goal_p  <= hit;
            miss_p  <= save;
            turn    <= ~turn;
            if (state == PLAY) begin
              ka <= ka_nx;
              kb <= kb_nx;
              if (a_wins || b_wins) begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
                winner  <= a_wins ? 2'b01 : 2'b10;
              end else if (turn) begin
                if (kb_nx == n) begin
                  state    <= SUDDEN;
                  sd_round <= 3'd1;
                end else begin
                  round <= round + 3'd1;
                end
              end
            end else if (turn) begin
              if (sa_nx != sb_nx) begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
                winner  <= (sa_nx > sb_nx) ? 2'b01 : 2'b10;
              end else if (sd_round == SD_LIM) begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
                winner  <= 2'b11;
              end else begin
                sd_round <= sd_round + 3'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shootout_ctrl.sv
// Bench for shootout_ctrl: count-based match model checked every
// cycle, plus hand-computed checkpoints from the match scenarios.
module tb_shootout_ctrl;

  localparam int SD_MAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode3 = 1'b0;
  logic       mode5 = 1'b0;
  logic       kick = 1'b0;
  logic       save = 1'b0;
  logic       invalid = 1'b0;
  logic       turn;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [2:0] round;
  logic [2:0] sd_round;
  logic       playing;
  logic       done;
  logic [1:0] winner;
  logic       goal_p;
  logic       miss_p;
  logic       reject_p;

  shootout_ctrl #(.SD_MAX(SD_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .mode3(mode3),
    .mode5(mode5),
    .kick(kick),
    .save(save),
    .invalid(invalid),
    .turn(turn),
    .score_a(score_a),
    .score_b(score_b),
    .round(round),
    .sd_round(sd_round),
    .playing(playing),
    .done(done),
    .winner(winner),
    .goal_p(goal_p),
    .miss_p(miss_p),
    .reject_p(reject_p)
  );

  always #5 clk = ~clk;

  // Match model: phase 0 idle, 1 regulation, 2 sudden death, 3 over.
  int ph = 0;
  int n = 0;
  int ta = 0;
  int tbk = 0;
  int ga = 0;
  int gb = 0;
  int e_turn = 0;
  int e_round = 0;
  int e_sd = 0;
  int e_win = 0;
  int e_goal = 0;
  int e_miss = 0;
  int e_rej = 0;

  always @(posedge clk) begin
    int shooter;
    int g;
    e_goal = 0;
    e_miss = 0;
    e_rej  = 0;
    if (rst) begin
      ph = 0; n = 0; ta = 0; tbk = 0; ga = 0; gb = 0;
      e_turn = 0; e_round = 0; e_sd = 0; e_win = 0;
    end else if (ph == 0 || ph == 3) begin
      if (mode3 != mode5) begin
        ph = 1; n = mode3 ? 3 : 5;
        ta = 0; tbk = 0; ga = 0; gb = 0;
        e_turn = 0; e_round = 1; e_sd = 0; e_win = 0;
      end
    end else if (kick && invalid) begin
      e_rej = 1;
    end else if (kick) begin
      g = save ? 0 : 1;
      e_goal = g;
      e_miss = 1 - g;
      shooter = e_turn;
      e_turn = 1 - e_turn;
      if (shooter == 0) ga += g;
      else gb += g;
      if (ph == 1) begin
        if (shooter == 0) ta++;
        else tbk++;
        if (ga > gb + (n - tbk)) begin
          ph = 3; e_win = 1;
        end else if (gb > ga + (n - ta)) begin
          ph = 3; e_win = 2;
        end else if (shooter == 1) begin
          if (tbk == n) begin
            ph = 2; e_sd = 1;
          end else begin
            e_round++;
          end
        end
      end else if (shooter == 1) begin
        if (ga != gb) begin
          ph = 3; e_win = (ga > gb) ? 1 : 2;
        end else if (e_sd == SD_MAX) begin
          ph = 3; e_win = 3;
        end else begin
          e_sd++;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  int pulses = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic check_model();
    chk("m_turn", int'(turn), e_turn);
    chk("m_score_a", int'(score_a), ga);
    chk("m_score_b", int'(score_b), gb);
    chk("m_round", int'(round), e_round);
    chk("m_sd_round", int'(sd_round), e_sd);
    chk("m_playing", int'(playing), (ph == 1 || ph == 2) ? 1 : 0);
    chk("m_done", int'(done), (ph == 3) ? 1 : 0);
    chk("m_winner", int'(winner), e_win);
    chk("m_goal_p", int'(goal_p), e_goal);
    chk("m_miss_p", int'(miss_p), e_miss);
    chk("m_reject_p", int'(reject_p), e_rej);
  endtask

  // Compare at the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input logic r, input logic m3, input logic m5,
                     input logic k, input logic s, input logic inv);
    @(negedge clk);
    check_model();
    pulses += int'(goal_p) + int'(miss_p);
    rst = r; mode3 = m3; mode5 = m5;
    kick = k; save = s; invalid = inv;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic shot(input logic s, input logic inv);
    cyc(0, 0, 0, 1, s, inv);
    idle();
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    chk("reset_playing", int'(playing), 0);
    chk("reset_score_a", int'(score_a), 0);
    chk("reset_winner", int'(winner), 0);

    cyc(0, 1, 1, 0, 0, 0);
    idle();
    chk("collide_playing", int'(playing), 0);
    shot(0, 0);
    chk("idle_kick_goal", int'(goal_p), 0);
    chk("idle_kick_score", int'(score_a), 0);

    // 3 rounds: A goal, B save, A goal, B save -> A decided 2-0
    cyc(0, 1, 0, 0, 0, 0);
    idle();
    pulses = 0;
    shot(0, 0);
    shot(1, 0);
    shot(0, 0);
    shot(1, 0);
    chk("m3_score_a", int'(score_a), 2);
    chk("m3_score_b", int'(score_b), 0);
    chk("m3_done", int'(done), 1);
    chk("m3_winner", int'(winner), 1);
    chk("m3_round", int'(round), 2);
    chk("m3_pulses", pulses, 4);

    // restart from DONE, 5 rounds of goals, then sudden death
    cyc(0, 0, 1, 0, 0, 0);
    idle();
    chk("restart_score", int'(score_a), 0);
    chk("restart_round", int'(round), 1);
    chk("restart_done", int'(done), 0);
    for (int i = 0; i < 10; i++) shot(0, 0);
    chk("m5_score_a", int'(score_a), 5);
    chk("m5_score_b", int'(score_b), 5);
    chk("m5_sd", int'(sd_round), 1);
    chk("m5_playing", int'(playing), 1);
    chk("m5_round", int'(round), 5);
    shot(0, 0);
    shot(1, 0);
    chk("sd_score_a", int'(score_a), 6);
    chk("sd_done", int'(done), 1);
    chk("sd_winner", int'(winner), 1);
    chk("sd_round_hold", int'(sd_round), 1);

    // invalid kick leaves everything unchanged
    cyc(0, 1, 0, 0, 0, 0);
    idle();
    shot(0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    idle();
    chk("rej_pulse", int'(reject_p), 1);
    chk("rej_turn", int'(turn), 1);
    chk("rej_score_a", int'(score_a), 1);
    chk("rej_score_b", int'(score_b), 0);
    idle();
    chk("rej_one_cycle", int'(reject_p), 0);
    shot(0, 0);
    chk("after_rej_b", int'(score_b), 1);

    // reset mid-match at 1-1 in a 5-round match
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle();
    shot(0, 0);
    shot(0, 0);
    chk("mid_score_b", int'(score_b), 1);
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    chk("mid_rst_score", int'(score_a), 0);
    chk("mid_rst_round", int'(round), 0);
    chk("mid_rst_playing", int'(playing), 0);

    // all saves: 0-0 through 3 rounds, then 7 sudden-death rounds -> draw
    cyc(0, 1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 6; i++) shot(1, 0);
    chk("saves_sd1", int'(sd_round), 1);
    chk("saves_playing", int'(playing), 1);
    for (int i = 0; i < 14; i++) shot(1, 0);
    chk("draw_done", int'(done), 1);
    chk("draw_winner", int'(winner), 3);
    chk("draw_sd", int'(sd_round), 7);
    chk("draw_score", int'(score_a) + int'(score_b), 0);

    // mode pulse mid-match is ignored
    cyc(0, 1, 0, 0, 0, 0);
    idle();
    shot(0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle();
    chk("mode_in_play", int'(score_a), 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
